// File: rtl/jit_pkg.sv
// Shared types and constants for the JVM bytecode translator.
package jit_pkg;

    typedef enum logic [1:0] {
        S_OPCODE  = 2'd0,
        S_OPERAND = 2'd1,
        S_EMIT    = 2'd2,
        S_ERR     = 2'd3
    } state_e;

    localparam logic [7:0] OP_WIDE = 8'hC4;

    // Template words are stored at this width and cast to WORD_W on the way out.
    localparam int unsigned TPL_WORD_MAX = 64;

    typedef struct packed {
        logic [TPL_WORD_MAX-1:0] word;
        logic                    last;
        logic                    patch;
    } tpl_entry_t;

    typedef struct packed {
        logic [3:0] cnt;
        logic [7:0] tpl;
        logic       legal;
        logic       wide_ok;
    } op_info_t;

    function automatic tpl_entry_t mk_tpl(input logic [TPL_WORD_MAX-1:0] word,
                                          input logic last, input logic patch);
        tpl_entry_t e;
        e.word  = word;
        e.last  = last;
        e.patch = patch;
        return e;
    endfunction

    function automatic op_info_t mk_op(input logic [3:0] cnt, input logic [7:0] tpl,
                                       input logic wide_ok);
        op_info_t o;
        o.cnt     = cnt;
        o.tpl     = tpl;
        o.legal   = 1'b1;
        o.wide_ok = wide_ok;
        return o;
    endfunction

endpackage

// File: rtl/bytecode_translator_if.sv
// Bytecode input stream and native-word output stream.
interface bytecode_translator_if #(
    parameter int unsigned WORD_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_byte;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_word;
    logic              out_last;

    modport master (
        output in_valid, in_byte, out_ready,
        input  in_ready, out_valid, out_word, out_last
    );

    modport slave (
        input  in_valid, in_byte, out_ready,
        output in_ready, out_valid, out_word, out_last
    );
endinterface

// File: rtl/xlate_rom.sv
// Combinational opcode-info table and native template table.
module xlate_rom
    import jit_pkg::*;
#(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned TPL_DEPTH = 256,
    localparam int unsigned TPL_AW   = (TPL_DEPTH > 1) ? $clog2(TPL_DEPTH) : 1
) (
    input  logic [7:0]        opcode_i,
    output logic [3:0]        op_cnt_o,
    output logic [TPL_AW-1:0] op_tpl_o,
    output logic              op_legal_o,
    output logic              op_wide_ok_o,
    input  logic [TPL_AW-1:0] tpl_addr_i,
    output logic [WORD_W-1:0] tpl_word_o,
    output logic              tpl_last_o,
    output logic              tpl_patch_o
);

    op_info_t   info;
    tpl_entry_t entry;

    // Opcode -> {operand bytes, template start, legal, wide_ok}; unlisted opcodes are illegal.
    always_comb begin
        info = '0;
        case (opcode_i)
            8'h00:   info = mk_op(4'd0, 8'd0, 1'b0);  // nop
            8'h10:   info = mk_op(4'd1, 8'd2, 1'b0);  // bipush
            8'h11:   info = mk_op(4'd2, 8'd3, 1'b0);  // sipush
            8'h15:   info = mk_op(4'd1, 8'd4, 1'b1);  // iload
            8'h5F:   info = mk_op(4'd0, 8'd5, 1'b0);  // swap
            8'h60:   info = mk_op(4'd0, 8'd1, 1'b0);  // iadd
            8'h84:   info = mk_op(4'd2, 8'd8, 1'b1);  // iinc
            default: info = '0;
        endcase
    end

    // Template word sequences; unused slots terminate immediately with a zero word.
    always_comb begin
        entry = mk_tpl('0, 1'b1, 1'b0);
        case (int'(tpl_addr_i))
            0:       entry = mk_tpl(64'h0000_0000_0000_0013, 1'b1, 1'b0);
            1:       entry = mk_tpl(64'h0000_0000_00A5_0533, 1'b1, 1'b0);
            2:       entry = mk_tpl(64'h0000_0000_1300_0000, 1'b1, 1'b1);
            3:       entry = mk_tpl(64'h0000_0000_1301_0000, 1'b1, 1'b1);
            4:       entry = mk_tpl(64'h0000_0000_2200_0000, 1'b1, 1'b1);
            5:       entry = mk_tpl(64'h0000_0000_3100_0001, 1'b0, 1'b0);
            6:       entry = mk_tpl(64'h0000_0000_3100_0002, 1'b0, 1'b0);
            7:       entry = mk_tpl(64'h0000_0000_3100_0003, 1'b1, 1'b0);
            8:       entry = mk_tpl(64'h0000_0000_4400_0000, 1'b0, 1'b1);
            9:       entry = mk_tpl(64'h0000_0000_4500_0000, 1'b1, 1'b1);
            default: entry = mk_tpl('0, 1'b1, 1'b0);
        endcase
    end

    assign op_cnt_o     = info.cnt;
    assign op_tpl_o     = TPL_AW'(info.tpl);
    assign op_legal_o   = info.legal;
    assign op_wide_ok_o = info.wide_ok;
    assign tpl_word_o   = WORD_W'(entry.word);
    assign tpl_last_o   = entry.last;
    assign tpl_patch_o  = entry.patch;

endmodule

// File: rtl/bytecode_translator.sv
// Translates JVM bytecode bytes into sequences of patched native instruction words.
module bytecode_translator
    import jit_pkg::*;
#(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned TPL_DEPTH = 256,
    parameter int unsigned MAX_OPS   = 4,
    parameter int unsigned PATCH_LSB = 0,
    parameter int unsigned PATCH_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    bytecode_translator_if.slave  bus,
    output logic                  busy,
    output logic                  err_illegal,
    output logic [7:0]            err_opcode,
    output logic [15:0]           insn_count
);

    localparam int unsigned TPL_AW = (TPL_DEPTH > 1) ? $clog2(TPL_DEPTH) : 1;
    localparam int unsigned OPND_W = 8 * MAX_OPS;
    localparam int unsigned CNT_W  = $clog2(MAX_OPS + 1);

    state_e              state_q, state_d;
    logic                wide_q, wide_d;
    logic [OPND_W-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TPL_AW-1:0]   tpl_addr_q, tpl_addr_d;
    logic [7:0]          err_opcode_q, err_opcode_d;
    logic [15:0]         insn_count_q, insn_count_d;

    logic [3:0]          op_cnt;
    logic [TPL_AW-1:0]   op_tpl;
    logic                op_legal;
    logic                op_wide_ok;
    logic [WORD_W-1:0]   tpl_word;
    logic                tpl_last;
    logic                tpl_patch;
    logic [4:0]          eff_cnt;

    logic                in_ready;
    logic                out_valid;
    logic [WORD_W-1:0]   out_word;
    logic                out_last;

    xlate_rom #(
        .WORD_W    (WORD_W),
        .TPL_DEPTH (TPL_DEPTH)
    ) u_rom (
        .opcode_i     (bus.in_byte),
        .op_cnt_o     (op_cnt),
        .op_tpl_o     (op_tpl),
        .op_legal_o   (op_legal),
        .op_wide_ok_o (op_wide_ok),
        .tpl_addr_i   (tpl_addr_q),
        .tpl_word_o   (tpl_word),
        .tpl_last_o   (tpl_last),
        .tpl_patch_o  (tpl_patch)
    );

    // A preceding WIDE prefix doubles the operand byte count.
    assign eff_cnt = wide_q ? {op_cnt, 1'b0} : {1'b0, op_cnt};

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d      = state_q;
        wide_d       = wide_q;
        opnd_d       = opnd_q;
        cnt_d        = cnt_q;
        tpl_addr_d   = tpl_addr_q;
        err_opcode_d = err_opcode_q;
        insn_count_d = insn_count_q;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_word     = '0;
        out_last     = 1'b0;

        case (state_q)
            S_OPCODE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (bus.in_byte == OP_WIDE) begin
                        if (wide_q) begin
                            state_d      = S_ERR;
                            err_opcode_d = bus.in_byte;
                        end else begin
                            wide_d = 1'b1;
                        end
                    end else if (!op_legal || (wide_q && !op_wide_ok) ||
                                 (32'(eff_cnt) > MAX_OPS)) begin
                        state_d      = S_ERR;
                        err_opcode_d = bus.in_byte;
                    end else begin
                        tpl_addr_d = op_tpl;
                        if (eff_cnt == 5'd0) begin
                            state_d = S_EMIT;
                        end else begin
                            cnt_d   = CNT_W'(eff_cnt);
                            state_d = S_OPERAND;
                        end
                    end
                end
            end
            S_OPERAND: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    // Big-endian accumulate: earlier bytes end up more significant.
                    opnd_d = (opnd_q << 8) | OPND_W'(bus.in_byte);
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                out_valid = 1'b1;
                out_word  = tpl_word;
                if (tpl_patch) begin
                    out_word[PATCH_LSB +: PATCH_W] = opnd_q[PATCH_W-1:0];
                end
                out_last = tpl_last;
                if (bus.out_ready) begin
                    if (tpl_last) begin
                        state_d      = S_OPCODE;
                        wide_d       = 1'b0;
                        opnd_d       = '0;
                        insn_count_d = insn_count_q + 16'd1;
                    end else if (tpl_addr_q == TPL_AW'(TPL_DEPTH - 1)) begin
                        tpl_addr_d = '0;
                    end else begin
                        tpl_addr_d = tpl_addr_q + TPL_AW'(1);
                    end
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
        endcase
    end

    // State and datapath registers; reset wins over any same-cycle handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_OPCODE;
            wide_q       <= 1'b0;
            opnd_q       <= '0;
            cnt_q        <= '0;
            tpl_addr_q   <= '0;
            err_opcode_q <= 8'h00;
            insn_count_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            wide_q       <= wide_d;
            opnd_q       <= opnd_d;
            cnt_q        <= cnt_d;
            tpl_addr_q   <= tpl_addr_d;
            err_opcode_q <= err_opcode_d;
            insn_count_q <= insn_count_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_word  = out_word;
    assign bus.out_last  = out_last;
    assign busy          = (state_q != S_OPCODE);
    assign err_illegal   = (state_q == S_ERR);
    assign err_opcode    = err_opcode_q;
    assign insn_count    = insn_count_q;

endmodule
